// File: rtl/bpsk_frame_sequencer.sv
// Frame controller for the BPSK transmit path: sequences sine generator reset/ready,
// sends a fixed preamble, then streams handshaked payload bits and holds a guard gap.
module bpsk_frame_sequencer #(
    parameter int          SPB              = 16,
    parameter int          PREAMBLE_LEN     = 8,
    parameter logic [31:0] PREAMBLE_PATTERN = 32'h000000AA,
    parameter int          PAYLOAD_LEN      = 32,
    parameter int          RST_CYCLES       = 4,
    parameter int          GUARD_CYCLES     = 64,
    parameter int          RDY_TIMEOUT      = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic PB,
    input  logic repeat_en,
    input  logic sine_rdy,
    input  logic data_valid,
    input  logic data_bit,
    output logic data_ready,
    output logic sine_rst,
    output logic sine_clk_en,
    output logic mod_en,
    output logic mod_bit,
    output logic busy,
    output logic underrun,
    output logic frame_done,
    output logic rdy_err
);

    localparam int SC_W = $clog2(SPB) + 1;
    localparam int PI_W = $clog2(PREAMBLE_LEN) + 1;
    localparam int PL_W = $clog2(PAYLOAD_LEN) + 1;
    localparam int RC_W = $clog2(RST_CYCLES) + 1;
    localparam int GC_W = $clog2(GUARD_CYCLES) + 1;
    localparam int TO_W = $clog2(RDY_TIMEOUT) + 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SRST  = 3'd1;
    localparam logic [2:0] S_SWAIT = 3'd2;
    localparam logic [2:0] S_PRE   = 3'd3;
    localparam logic [2:0] S_PAY   = 3'd4;
    localparam logic [2:0] S_GUARD = 3'd5;

    logic [2:0]      r_state;
    logic            r_pb_s1, r_pb_s2, r_pb_d;
    logic [SC_W-1:0] r_sample_cnt;
    logic [PI_W-1:0] r_pidx;
    logic [PL_W-1:0] r_fetched;
    logic [PL_W-1:0] r_sent;
    logic [RC_W-1:0] r_rst_cnt;
    logic [GC_W-1:0] r_guard_cnt;
    logic [TO_W-1:0] r_wait_cnt;
    logic            r_have;
    logic            r_have_bit;
    logic            r_pay_bit;
    logic            r_bit_loaded;

    logic       w_pb_evt;
    logic       w_run;
    logic       w_bnd;
    logic       w_take;
    logic [4:0] w_pat_idx;

    assign w_pb_evt  = r_pb_s2 & ~r_pb_d;
    assign w_run     = (r_state == S_PRE) || ((r_state == S_PAY) && r_bit_loaded);
    assign w_bnd     = w_run && (r_sample_cnt == SC_W'(SPB - 1));
    assign w_take    = data_valid && data_ready;
    assign w_pat_idx = 5'(PREAMBLE_LEN - 1) - 5'(r_pidx);

    assign data_ready  = ((r_state == S_PRE) || (r_state == S_PAY)) && !r_have
                         && (r_fetched < PL_W'(PAYLOAD_LEN));
    assign sine_rst    = (r_state == S_IDLE) || (r_state == S_SRST) || (r_state == S_GUARD);
    assign sine_clk_en = w_run;
    assign mod_en      = w_run;
    assign busy        = (r_state != S_IDLE);
    assign underrun    = (r_state == S_PAY) && !r_bit_loaded;
    assign frame_done  = (r_state == S_GUARD) && (r_guard_cnt == GC_W'(GUARD_CYCLES - 1)) && !w_pb_evt;
    assign rdy_err     = (r_state == S_SWAIT) && !sine_rdy && (r_wait_cnt == TO_W'(RDY_TIMEOUT - 1))
                         && !w_pb_evt;
    assign mod_bit     = (r_state == S_PRE) ? PREAMBLE_PATTERN[w_pat_idx] :
                         (r_state == S_PAY) ? r_pay_bit : 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pb_s1 <= 1'b0;
            r_pb_s2 <= 1'b0;
            r_pb_d  <= 1'b0;
        end else begin
            r_pb_s1 <= PB;
            r_pb_s2 <= r_pb_s1;
            r_pb_d  <= r_pb_s2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_pb_evt) begin
            // A button event outside IDLE aborts; any buffered bit is dropped with it.
            r_state      <= (!rst && (r_state == S_IDLE)) ? S_SRST : S_IDLE;
            r_sample_cnt <= '0;
            r_pidx       <= '0;
            r_fetched    <= '0;
            r_sent       <= '0;
            r_rst_cnt    <= '0;
            r_guard_cnt  <= '0;
            r_wait_cnt   <= '0;
            r_have       <= 1'b0;
            r_have_bit   <= 1'b0;
            r_pay_bit    <= 1'b0;
            r_bit_loaded <= 1'b0;
        end else begin
            if (w_take) begin
                r_have     <= 1'b1;
                r_have_bit <= data_bit;
                r_fetched  <= r_fetched + 1'b1;
            end
            if (w_run) begin
                r_sample_cnt <= w_bnd ? '0 : r_sample_cnt + 1'b1;
            end
            case (r_state)
                S_SRST: begin
                    if (r_rst_cnt == RC_W'(RST_CYCLES - 1)) begin
                        r_rst_cnt <= '0;
                        r_state   <= S_SWAIT;
                    end else begin
                        r_rst_cnt <= r_rst_cnt + 1'b1;
                    end
                end
                S_SWAIT: begin
                    if (sine_rdy) begin
                        r_wait_cnt <= '0;
                        r_state    <= S_PRE;
                    end else if (r_wait_cnt == TO_W'(RDY_TIMEOUT - 1)) begin
                        r_wait_cnt <= '0;
                        r_state    <= S_IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                S_PRE: begin
                    if (w_bnd) begin
                        if (r_pidx == PI_W'(PREAMBLE_LEN - 1)) begin
                            r_pidx       <= '0;
                            r_state      <= S_PAY;
                            r_bit_loaded <= r_have;
                            if (r_have) begin
                                r_pay_bit <= r_have_bit;
                                r_have    <= 1'b0;
                            end
                        end else begin
                            r_pidx <= r_pidx + 1'b1;
                        end
                    end
                end
                S_PAY: begin
                    if (!r_bit_loaded) begin
                        // Stalled: the first buffered bit restarts the symbol clock.
                        if (r_have) begin
                            r_pay_bit    <= r_have_bit;
                            r_have       <= 1'b0;
                            r_bit_loaded <= 1'b1;
                        end
                    end else if (w_bnd) begin
                        if (r_sent == PL_W'(PAYLOAD_LEN - 1)) begin
                            r_sent       <= '0;
                            r_bit_loaded <= 1'b0;
                            r_state      <= S_GUARD;
                        end else begin
                            r_sent       <= r_sent + 1'b1;
                            r_bit_loaded <= r_have;
                            if (r_have) begin
                                r_pay_bit <= r_have_bit;
                                r_have    <= 1'b0;
                            end
                        end
                    end
                end
                S_GUARD: begin
                    if (r_guard_cnt == GC_W'(GUARD_CYCLES - 1)) begin
                        r_guard_cnt <= '0;
                        r_fetched   <= '0;
                        r_have      <= 1'b0;
                        r_pay_bit   <= 1'b0;
                        r_state     <= repeat_en ? S_SRST : S_IDLE;
                    end else begin
                        r_guard_cnt <= r_guard_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bpsk_frame_sequencer.sv
// Directed bench for bpsk_frame_sequencer with SPB=4, 4-bit preamble 1010, 4-bit payload.
module tb_bpsk_frame_sequencer;

    logic clk = 1'b0;
    logic rst, PB, repeat_en, sine_rdy, data_valid, data_bit;
    logic data_ready, sine_rst, sine_clk_en, mod_en, mod_bit;
    logic busy, underrun, frame_done, rdy_err;

    int n_cmp   = 0;
    int n_err   = 0;
    int n_xfer  = 0;
    int src_idx = 0;
    int pb_left = 0;
    logic [0:3] src_q = 4'b1101;

    bpsk_frame_sequencer #(
        .SPB(4), .PREAMBLE_LEN(4), .PREAMBLE_PATTERN(32'h0000000A), .PAYLOAD_LEN(4),
        .RST_CYCLES(2), .GUARD_CYCLES(8), .RDY_TIMEOUT(16)
    ) dut (
        .clk(clk), .rst(rst), .PB(PB), .repeat_en(repeat_en), .sine_rdy(sine_rdy),
        .data_valid(data_valid), .data_bit(data_bit), .data_ready(data_ready),
        .sine_rst(sine_rst), .sine_clk_en(sine_clk_en), .mod_en(mod_en), .mod_bit(mod_bit),
        .busy(busy), .underrun(underrun), .frame_done(frame_done), .rdy_err(rdy_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        logic xfer;
        for (int k = 0; k < n; k++) begin
            xfer = data_valid && data_ready;
            @(negedge clk);
            if (xfer) begin
                n_xfer++;
                src_idx++;
            end
            data_bit = (src_idx < 4) ? src_q[src_idx] : 1'b0;
            if (pb_left > 0) begin
                pb_left--;
                if (pb_left == 0) PB = 1'b0;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic src_reset();
        src_idx  = 0;
        n_xfer   = 0;
        data_bit = src_q[0];
    endtask

    task automatic press(input int hold);
        PB      = 1'b1;
        pb_left = hold;
    endtask

    // Press, walk through the 2-cycle generator reset, stop on the first preamble cycle.
    task automatic start_frame(input string tag, input int hold);
        press(hold);
        step(2);
        chk({tag, "_pre_evt_busy"}, busy, 1'b0);
        step(1);
        chk({tag, "_srst0"}, {busy, sine_rst, mod_en}, 3'b110);
        step(1);
        chk({tag, "_srst1"}, {busy, sine_rst, mod_en}, 3'b110);
        step(1);
        chk({tag, "_swait"}, {busy, sine_rst, sine_clk_en}, 3'b100);
        step(1);
    endtask

    task automatic check_frame(input string tag);
        logic [7:0] exp_seq;
        exp_seq = 8'b1010_1101;
        for (int i = 0; i < 32; i++) begin
            chk({tag, "_en"}, {mod_en, sine_clk_en, underrun}, 3'b110);
            chk({tag, "_bit"}, mod_bit, exp_seq[7 - i / 4]);
            step(1);
        end
        for (int g = 0; g < 8; g++) begin
            chk({tag, "_guard"}, {sine_rst, mod_en, sine_clk_en, mod_bit}, 4'b1000);
            chk({tag, "_fdone"}, frame_done, (g == 7));
            step(1);
        end
    endtask

    initial begin
        logic en_e, bit_e, seen;
        rst = 1'b1; PB = 1'b0; repeat_en = 1'b0; sine_rdy = 1'b1; data_valid = 1'b1;
        data_bit = src_q[0];
        step(3);
        rst = 1'b0;
        chk("reset_outs", {sine_rst, busy, data_ready, sine_clk_en, mod_en, mod_bit,
                           underrun, frame_done, rdy_err}, 9'b1_0000_0000);
        step(2);

        // Held button, immediate ready, continuous data.
        src_reset();
        start_frame("f_hold", 50);
        check_frame("f_hold");
        chk("f_hold_idle", busy, 1'b0);
        chk("f_hold_xfers", n_xfer, 4);
        step(10);
        chk("f_hold_single", busy, 1'b0);

        // Upstream stall before the third payload bit.
        src_reset();
        start_frame("stall", 3);
        for (int i = 0; i < 16; i++) begin
            chk("stall_pre_bit", mod_bit, (i / 4 == 0 || i / 4 == 2));
            step(1);
        end
        for (int c = 0; c < 21; c++) begin
            en_e  = !(c >= 8 && c <= 12);
            bit_e = (c < 8) ? 1'b1 : ((c < 17) ? 1'b0 : 1'b1);
            chk("stall_en", {mod_en, sine_clk_en, underrun}, {en_e, en_e, !en_e});
            if (en_e) chk("stall_bit", mod_bit, bit_e);
            data_valid = !(c >= 1 && c <= 10);
            step(1);
        end
        for (int g = 0; g < 8; g++) begin
            chk("stall_fdone", frame_done, (g == 7));
            step(1);
        end
        chk("stall_xfers", n_xfer, 4);
        chk("stall_idle", busy, 1'b0);

        // Generator never ready.
        src_reset();
        sine_rdy = 1'b0;
        press(3);
        step(5);
        for (int w = 0; w < 16; w++) begin
            chk("tmo_err", rdy_err, (w == 15));
            chk("tmo_ready", {data_ready, sine_rst, busy}, 3'b001);
            step(1);
        end
        chk("tmo_idle", {busy, sine_rst, rdy_err}, 3'b010);
        chk("tmo_xfers", n_xfer, 0);
        sine_rdy = 1'b1;
        step(4);

        // Abort during the second preamble bit, then a clean restart.
        src_reset();
        start_frame("abort", 3);
        step(3);
        press(2);
        step(2);
        chk("abort_bit2", {busy, mod_en, mod_bit}, 3'b110);
        step(1);
        chk("abort_idle", {busy, sine_rst, mod_en, mod_bit}, 4'b0100);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            seen = seen | frame_done;
            step(1);
        end
        chk("abort_no_fdone", seen, 1'b0);
        src_reset();
        start_frame("restart", 3);
        check_frame("restart");
        chk("restart_xfers", n_xfer, 4);

        // Automatic repeat: two back-to-back frames.
        step(3);
        repeat_en = 1'b1;
        src_reset();
        start_frame("rep1", 3);
        check_frame("rep1");
        chk("rep1_xfers", n_xfer, 4);
        repeat_en = 1'b0;
        src_reset();
        chk("rep_srst0", {busy, sine_rst, mod_en}, 3'b110);
        step(1);
        chk("rep_srst1", {busy, sine_rst}, 2'b11);
        step(1);
        chk("rep_swait", {busy, sine_rst}, 2'b10);
        step(1);
        check_frame("rep2");
        chk("rep2_xfers", n_xfer, 4);
        chk("rep2_idle", busy, 1'b0);

        // Synchronous reset in the middle of a frame.
        src_reset();
        start_frame("mid_rst", 3);
        step(5);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("mid_rst_outs", {busy, sine_rst, mod_en, frame_done, data_ready}, 5'b01000);
        step(20);
        chk("mid_rst_idle", {busy, frame_done}, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bpsk_frame_sequencer.md
Name: bpsk_frame_sequencer

Overview:
Frame-level controller for the BPSK transmit datapath (sine generator + modulator). A push-button starts a frame. The block then sequences the generator through reset and ready, emits a fixed preamble, and streams PAYLOAD_LEN data bits from an upstream bit source over a valid/ready handshake. It then holds a guard gap and either repeats or returns to idle. It drives sine_rst, sine_clk_en, mod_en and the bit value to the modulator, at SPB sine samples per bit.

Parameters:
SPB, 16, sine samples (enabled clk cycles) per symbol; >=2
PREAMBLE_LEN, 8, preamble length in bits; 1..32
PREAMBLE_PATTERN, 32'h000000AA, preamble bits; bit [PREAMBLE_LEN-1] sent first
PAYLOAD_LEN, 32, payload bits per frame; >=1
RST_CYCLES, 4, cycles sine_rst held high at frame start; >=1
GUARD_CYCLES, 64, idle cycles after payload; >=1
RDY_TIMEOUT, 255, max cycles waiting for sine_rdy

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
PB  in  1  raw push-button level
repeat_en  in  1  1 = start the next frame automatically after the guard
sine_rdy  in  1  sine generator ready
data_valid  in  1  upstream payload bit valid
data_bit  in  1  upstream payload bit
data_ready  out  1  this block accepts data_bit
sine_rst  out  1  sine generator reset
sine_clk_en  out  1  sine generator advance enable
mod_en  out  1  modulator enable
mod_bit  out  1  symbol bit (0 = 0 deg, 1 = 180 deg)
busy  out  1  state != IDLE
underrun  out  1  level: payload stalled waiting for data
frame_done  out  1  one-cycle pulse at end of guard
rdy_err  out  1  one-cycle pulse on sine_rdy timeout

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE, sine_rst=1, all other outputs 0, all counters and flags cleared.
- PB path: 2-FF synchronizer, then rising-edge detect gives pb_evt (1 cycle). A held button produces exactly one event.
- Priority: rst > pb_evt > normal transitions.
  - pb_evt in IDLE starts a frame.
  - pb_evt in any other state aborts to IDLE next cycle; the held data bit (have) is discarded.
- IDLE: sine_rst=1, sine_clk_en=0, mod_en=0. On pb_evt go to SINE_RESET.
- SINE_RESET: sine_rst=1 for exactly RST_CYCLES cycles, then SINE_WAIT.
- SINE_WAIT: sine_rst=0, enables 0.
  - sine_rdy=1 -> PREAMBLE.
  - After RDY_TIMEOUT cycles without sine_rdy: rdy_err pulse, go to IDLE.
- Symbol timing: sample_cnt counts 0..SPB-1 only in cycles where sine_clk_en=1. A bit boundary is a cycle with sample_cnt==SPB-1 and sine_clk_en=1.
- PREAMBLE:
  - sine_clk_en=1, mod_en=1.
  - mod_bit=PREAMBLE_PATTERN[PREAMBLE_LEN-1-pidx], i.e. MSB first.
  - pidx increments at each bit boundary; the last boundary transfers to PAYLOAD.
- Data buffer: 1-bit register `have`.
  - data_ready = (state is PREAMBLE or PAYLOAD) && !have && fetched < PAYLOAD_LEN.
  - Transfer occurs when data_valid && data_ready: data_bit is stored, have=1, fetched++.
  - Transfers occur only when data_ready=1. data_valid with data_ready=0 is ignored.
- PAYLOAD load rule, at the preamble's last boundary or a payload bit boundary while bits remain:
  - have=1: mod_bit takes the buffered bit next cycle and have clears, giving seamless symbols with no gap.
  - have=0: bit_loaded=0 and the block stalls.
- Stall (PAYLOAD with bit_loaded=0):
  - sine_clk_en=0, mod_en=0, underrun=1, sample_cnt holds.
  - When have=1, load the bit; outputs re-enable the following cycle.
- After the last boundary of payload bit PAYLOAD_LEN: go to GUARD.
- GUARD:
  - sine_clk_en=0, mod_en=0, sine_rst=1, mod_bit=0.
  - Lasts GUARD_CYCLES cycles.
  - Last cycle: frame_done=1, then go to SINE_RESET if repeat_en=1, else IDLE.
- Data accepted in the same cycle as pb_evt abort is discarded.
- Reset mid-frame: everything returns to reset values on the next edge; no frame_done.
- mod_bit is registered and changes only at bit boundaries/loads. Outside PREAMBLE/PAYLOAD, mod_bit=0.
- Counter widths: sized by $clog2 of the respective parameter +1. No wrap is permitted except sample_cnt (SPB-1 -> 0).

Test Plan:
- Bench parameters for all scenarios: SPB=4, PREAMBLE_LEN=4, PREAMBLE_PATTERN=4'b1010, PAYLOAD_LEN=4, RST_CYCLES=2, GUARD_CYCLES=8, RDY_TIMEOUT=16.
1. Reset -> sine_rst=1, busy=0, other outputs 0. One PB press held 50 cycles -> exactly one frame; sine_rst high exactly 2 cycles after the pb_evt.
2. sine_rdy=1 immediately, data_valid always 1, bits 1,1,0,1 -> mod_bit sequence 1,0,1,0,1,1,0,1, each held 4 cycles with mod_en continuously 1 (32 cycles). Then 8 guard cycles, frame_done pulse at the last one, IDLE.
3. Same as 2, but data_valid low for 10 cycles before the 3rd payload bit -> underrun=1 and sine_clk_en=mod_en=0 for the stall; the bit resumes with a full 4 samples; total payload 4 bits.
4. sine_rdy held 0 -> rdy_err pulse 16 cycles after entering SINE_WAIT; return to IDLE; data_ready never asserted.
5. PB pressed again during the 2nd preamble bit -> IDLE next cycle, sine_rst=1, mod_en=0, no frame_done. A subsequent press starts a clean frame beginning with preamble bit 1.
6. repeat_en=1 -> after frame_done, SINE_RESET immediately. Two full frames complete with identical preamble; fetched count resets per frame (4 transfers each).
